// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified memory between instruction fetch and
// load/store. One access outstanding at a time, bounded by a watchdog.
//
// Build option: define ARB_RR_EN for round-robin arbitration when both
// requesters collide; otherwise load/store has fixed priority over fetch.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if_req/if_addr                 fetch read request (held until if_gnt)
//   if_gnt/if_valid                fetch grant / completion pulses
//   d_req/d_we/d_addr/d_wdata      load/store request (held until d_gnt)
//   d_gnt/d_valid                  load/store grant / completion pulses
//   rdata, err                     read data and timeout flag with valid
//   busy                           high while an access is in flight
//   mem_read/mem_write             memory strobes
//   mem_read_addr/mem_write_addr   memory addresses (same latched value)
//   mem_wr_data                    memory write data
//   mem_rd_data/mem_rd_done/mem_wr_done  memory responses
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_valid,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic                  busy,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_rd_done,
  input  logic                  mem_wr_done
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  owner_d, owner_d_nxt;   // 1 = load/store owns the access
  logic                  op_we, op_we_nxt;
  logic                  if_gnt_nxt, if_valid_nxt, d_gnt_nxt, d_valid_nxt;
  logic                  err_nxt, busy_nxt, mem_read_nxt, mem_write_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic [DATA_WIDTH-1:0] rdata_nxt, wdata, wdata_nxt;
  logic                  pick_d_c;
  logic                  done_c;

`ifdef ARB_RR_EN
  logic                  last_d, last_d_nxt;     // 1 = last grant went to load/store

  // On a collision the requester that did not win last time goes first.
  assign pick_d_c = d_req && (!if_req || !last_d);
`else
  assign pick_d_c = d_req;
`endif

  // Only the completion matching the latched operation ends the access.
  assign done_c = op_we ? mem_wr_done : mem_rd_done;

  assign mem_read_addr  = addr;
  assign mem_write_addr = addr;
  assign mem_wr_data    = wdata;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    owner_d_nxt   = owner_d;
    op_we_nxt     = op_we;
    addr_nxt      = addr;
    wdata_nxt     = wdata;
    rdata_nxt     = rdata;
    busy_nxt      = busy;
    mem_read_nxt  = mem_read;
    mem_write_nxt = mem_write;
    if_gnt_nxt    = 1'b0;
    d_gnt_nxt     = 1'b0;
    if_valid_nxt  = 1'b0;
    d_valid_nxt   = 1'b0;
    err_nxt       = 1'b0;
`ifdef ARB_RR_EN
    last_d_nxt    = last_d;
`endif

    case (state)
      IDLE: begin
        mem_read_nxt  = 1'b0;
        mem_write_nxt = 1'b0;
        busy_nxt      = 1'b0;
        if (d_req || if_req) begin
          state_nxt   = ACCESS;
          cnt_nxt     = '0;
          busy_nxt    = 1'b1;
          owner_d_nxt = pick_d_c;
`ifdef ARB_RR_EN
          last_d_nxt  = pick_d_c;
`endif
          if (pick_d_c) begin
            d_gnt_nxt     = 1'b1;
            op_we_nxt     = d_we;
            addr_nxt      = d_addr;
            mem_read_nxt  = !d_we;
            mem_write_nxt = d_we;
            if (d_we) wdata_nxt = d_wdata;
          end else begin
            if_gnt_nxt    = 1'b1;
            op_we_nxt     = 1'b0;
            addr_nxt      = if_addr;
            mem_read_nxt  = 1'b1;
          end
        end
      end

      ACCESS: begin
        if (done_c || cnt == CNT_LAST) begin
          // Completion or watchdog expiry: release memory and report.
          state_nxt     = IDLE;
          busy_nxt      = 1'b0;
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          err_nxt       = !done_c;
          d_valid_nxt   = owner_d;
          if_valid_nxt  = !owner_d;
          if (done_c && !op_we) rdata_nxt = mem_rd_data;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      owner_d   <= 1'b0;
      op_we     <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      err       <= 1'b0;
`ifdef ARB_RR_EN
      last_d    <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      owner_d   <= owner_d_nxt;
      op_we     <= op_we_nxt;
      addr      <= addr_nxt;
      wdata     <= wdata_nxt;
      rdata     <= rdata_nxt;
      busy      <= busy_nxt;
      mem_read  <= mem_read_nxt;
      mem_write <= mem_write_nxt;
      if_gnt    <= if_gnt_nxt;
      d_gnt     <= d_gnt_nxt;
      if_valid  <= if_valid_nxt;
      d_valid   <= d_valid_nxt;
      err       <= err_nxt;
`ifdef ARB_RR_EN
      last_d    <= last_d_nxt;
`endif
    end
  end

endmodule
